// File: rtl/reflet_mem_bist_pkg.sv
// rtl/reflet_mem_bist_pkg.sv - shared state encoding, index width and pattern helper for the memory BIST
package reflet_mem_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Word-index counter width; a one-word window still needs a 1-bit counter.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Callers truncate the result to their data width (mod 2^word_size).
  function automatic logic [63:0] pattern_raw(input logic [63:0] seed,
                                              input logic [63:0] stride,
                                              input logic [63:0] index);
    return seed + index * stride;
  endfunction

endpackage

// File: rtl/reflet_mem_bist_pattern.sv
// rtl/reflet_mem_bist_pattern.sv - combinational address and pattern generator for the memory BIST
module reflet_mem_bist_pattern
  import reflet_mem_bist_pkg::*;
#(
  parameter int                   word_size = 8,
  parameter int                   addr_size = 8,
  parameter int                   idx_w     = 2,
  parameter logic [addr_size-1:0] base_addr = 8'h80,
  parameter logic [word_size-1:0] seed      = 8'h5A,
  parameter logic [word_size-1:0] stride    = 8'h11
) (
  input  logic [idx_w-1:0]     addr_idx_i,
  input  logic [idx_w-1:0]     data_idx_i,
  input  logic                 invert_i,
  output logic [addr_size-1:0] addr_o,
  output logic [word_size-1:0] data_o
);

  logic [word_size-1:0] pat;

  // Address arithmetic wraps silently at the top of the address space.
  assign addr_o = base_addr + addr_size'(addr_idx_i);
  assign pat    = word_size'(pattern_raw(64'(seed), 64'(stride), 64'(data_idx_i)));
  assign data_o = pat ^ {word_size{invert_i}};

endmodule

// File: rtl/reflet_mem_bist.sv
// rtl/reflet_mem_bist.sv - write/read-back/compare memory BIST initiator; REFLET_MEM_BIST_INVERT_EN adds an inverted second pass
module reflet_mem_bist
  import reflet_mem_bist_pkg::*;
#(
  parameter int                   word_size  = 8,
  parameter int                   addr_size  = 8,
  parameter logic [addr_size-1:0] base_addr  = 8'h80,
  parameter int                   array_size = 3,
  parameter logic [word_size-1:0] seed       = 8'h5A,
  parameter logic [word_size-1:0] stride     = 8'h11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [addr_size-1:0] addr,
  output logic [word_size-1:0] data_out,
  output logic                 write_en,
  input  logic [word_size-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass
);

  localparam int               idx_w    = idx_width(array_size);
  localparam logic [idx_w-1:0] last_idx = idx_w'(array_size - 1);

  state_e           state_q, state_d;
  logic [idx_w-1:0] cnt_q, cnt_d;
  logic [idx_w-1:0] cmp_idx_q, cmp_idx_d;
  logic             cmp_valid_q, cmp_valid_d;
  logic             error_q, error_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             inv_q;
  logic             finish;
  logic             mismatch;
  logic [idx_w-1:0] data_idx;
  logic [addr_size-1:0] gen_addr;
  logic [word_size-1:0] gen_data;

`ifdef REFLET_MEM_BIST_INVERT_EN
  logic inv_d;
`else
  assign inv_q = 1'b0;
`endif

  // Writes use the live counter; compares use the index delayed by the read latency.
  assign data_idx = (state_q == ST_WRITE) ? cnt_q : cmp_idx_q;

  reflet_mem_bist_pattern #(
    .word_size (word_size),
    .addr_size (addr_size),
    .idx_w     (idx_w),
    .base_addr (base_addr),
    .seed      (seed),
    .stride    (stride)
  ) u_pattern (
    .addr_idx_i (cnt_q),
    .data_idx_i (data_idx),
    .invert_i   (inv_q),
    .addr_o     (gen_addr),
    .data_o     (gen_data)
  );

  assign mismatch = cmp_valid_q && (data_in != gen_data);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmp_idx_d   = cnt_q;
    cmp_valid_d = 1'b0;
    error_d     = error_q | mismatch;
    done_d      = done_q;
    pass_d      = pass_q;
    finish      = 1'b0;
`ifdef REFLET_MEM_BIST_INVERT_EN
    inv_d       = inv_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WRITE;
          cnt_d   = '0;
          error_d = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
`ifdef REFLET_MEM_BIST_INVERT_EN
          inv_d   = 1'b0;
`endif
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_q + idx_w'(1);
        if (cnt_q == last_idx) begin
          state_d = ST_READ;
          cnt_d   = '0;
        end
      end
      ST_READ: begin
        cmp_valid_d = 1'b1;
        cnt_d       = cnt_q + idx_w'(1);
        if (cnt_q == last_idx) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
`ifdef REFLET_MEM_BIST_INVERT_EN
        if (!inv_q) begin
          state_d = ST_WRITE;
          cnt_d   = '0;
          inv_d   = 1'b1;
        end else begin
          finish = 1'b1;
        end
`else
        finish = 1'b1;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    if (finish) begin
      state_d = ST_DONE;
      done_d  = 1'b1;
      pass_d  = !error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmp_idx_q   <= '0;
      cmp_valid_q <= 1'b0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmp_idx_q   <= cmp_idx_d;
      cmp_valid_q <= cmp_valid_d;
      error_q     <= error_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

`ifdef REFLET_MEM_BIST_INVERT_EN
  always_ff @(posedge clk) begin
    if (!reset) inv_q <= 1'b0;
    else        inv_q <= inv_d;
  end
`endif

  // The bus is OR-combined, so every output is forced to zero when not driving.
  assign write_en = (state_q == ST_WRITE);
  assign addr     = (state_q == ST_WRITE || state_q == ST_READ) ? gen_addr : '0;
  assign data_out = write_en ? gen_data : '0;
  assign busy     = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done     = done_q;
  assign pass     = pass_q;

endmodule

// File: tb/tb_reflet_mem_bist.sv
// tb/tb_reflet_mem_bist.sv - directed self-checking bench: three BIST instances, each against its own RAM model
module tb_reflet_mem_bist;

`ifdef REFLET_MEM_BIST_INVERT_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_v [3];
  logic [7:0] b_addr  [3];
  logic [7:0] b_dout  [3];
  logic       b_we    [3];
  logic [7:0] rd      [3];
  logic       b_busy  [3];
  logic       b_done  [3];
  logic       b_pass  [3];
  logic [7:0] mem     [3][256];
  logic       fault_en;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  reflet_mem_bist u_def (
    .clk(clk), .reset(rst_n), .start(start_v[0]), .addr(b_addr[0]), .data_out(b_dout[0]),
    .write_en(b_we[0]), .data_in(rd[0]), .busy(b_busy[0]), .done(b_done[0]), .pass(b_pass[0])
  );

  reflet_mem_bist #(.base_addr(8'hFE)) u_wrap (
    .clk(clk), .reset(rst_n), .start(start_v[1]), .addr(b_addr[1]), .data_out(b_dout[1]),
    .write_en(b_we[1]), .data_in(rd[1]), .busy(b_busy[1]), .done(b_done[1]), .pass(b_pass[1])
  );

  reflet_mem_bist #(.array_size(1)) u_one (
    .clk(clk), .reset(rst_n), .start(start_v[2]), .addr(b_addr[2]), .data_out(b_dout[2]),
    .write_en(b_we[2]), .data_in(rd[2]), .busy(b_busy[2]), .done(b_done[2]), .pass(b_pass[2])
  );

  // Synchronous RAM, read latency 1; the injector corrupts reads of 0x81 on u_def only.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (b_we[g]) begin
        mem[g][b_addr[g]] <= b_dout[g];
        rd[g] <= 8'h00;
      end else if (fault_en && g == 0 && b_addr[g] == 8'h81) begin
        rd[g] <= 8'h6A;
      end else begin
        rd[g] <= mem[g][b_addr[g]];
      end
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_bus(input string tag, input int s);
    check({tag, "_addr"}, b_addr[s], 8'h00);
    check({tag, "_dout"}, b_dout[s], 8'h00);
    check({tag, "_we"},   8'(b_we[s]), 8'h00);
    check({tag, "_busy"}, 8'(b_busy[s]), 8'h00);
    check({tag, "_done"}, 8'(b_done[s]), 8'h00);
    check({tag, "_pass"}, 8'(b_pass[s]), 8'h00);
  endtask

  task automatic expect_run(input string tag, input int s, input int n,
                            input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                            input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                            input logic exp_pass);
    logic [7:0] a [3];
    logic [7:0] d [3];
    logic [7:0] inv;
    a[0] = a0; a[1] = a1; a[2] = a2;
    d[0] = d0; d[1] = d1; d[2] = d2;
    start_v[s] = 1'b1;
    step();
    start_v[s] = 1'b0;
    check({tag, "_clr_done"}, 8'(b_done[s]), 8'h00);
    check({tag, "_clr_pass"}, 8'(b_pass[s]), 8'h00);
    for (int p = 0; p < PASSES; p++) begin
      inv = (p == 1) ? 8'hFF : 8'h00;
      for (int i = 0; i < n; i++) begin
        check($sformatf("%s_wr%0d_%0d_we", tag, p, i),   8'(b_we[s]), 8'h01);
        check($sformatf("%s_wr%0d_%0d_addr", tag, p, i), b_addr[s], a[i]);
        check($sformatf("%s_wr%0d_%0d_data", tag, p, i), b_dout[s], d[i] ^ inv);
        check($sformatf("%s_wr%0d_%0d_busy", tag, p, i), 8'(b_busy[s]), 8'h01);
        step();
      end
      for (int i = 0; i < n; i++) begin
        if (p == 0 && i == 0) start_v[s] = 1'b1;
        check($sformatf("%s_rd%0d_%0d_we", tag, p, i),   8'(b_we[s]), 8'h00);
        check($sformatf("%s_rd%0d_%0d_addr", tag, p, i), b_addr[s], a[i]);
        check($sformatf("%s_rd%0d_%0d_data", tag, p, i), b_dout[s], 8'h00);
        step();
        start_v[s] = 1'b0;
      end
      check($sformatf("%s_drain%0d_busy", tag, p), 8'(b_busy[s]), 8'h01);
      check($sformatf("%s_drain%0d_addr", tag, p), b_addr[s], 8'h00);
      check($sformatf("%s_drain%0d_done", tag, p), 8'(b_done[s]), 8'h00);
      step();
    end
    check({tag, "_done"}, 8'(b_done[s]), 8'h01);
    check({tag, "_pass"}, 8'(b_pass[s]), 8'(exp_pass));
    check({tag, "_busy"}, 8'(b_busy[s]), 8'h00);
    check({tag, "_idle_addr"}, b_addr[s], 8'h00);
    // Start held in DONE restarts on the very next edge.
    start_v[s] = 1'b1;
    step();
    start_v[s] = 1'b0;
    check({tag, "_rs_we"},   8'(b_we[s]), 8'h01);
    check({tag, "_rs_addr"}, b_addr[s], a[0]);
    check({tag, "_rs_done"}, 8'(b_done[s]), 8'h00);
    for (int c = 0; c < 64 && b_done[s] !== 1'b1; c++) step();
    check({tag, "_rs_final_done"}, 8'(b_done[s]), 8'h01);
    check({tag, "_rs_final_pass"}, 8'(b_pass[s]), 8'(exp_pass));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    fault_en = 1'b0;
    for (int g = 0; g < 3; g++) start_v[g] = 1'b0;
    for (int g = 0; g < 3; g++)
      for (int w = 0; w < 256; w++) mem[g][w] = 8'h00;
    step();
    step();
    for (int g = 0; g < 3; g++) check_idle_bus($sformatf("rst%0d", g), g);
    rst_n = 1'b1;
    step();

    expect_run("basic", 0, 3, 8'h80, 8'h81, 8'h82, 8'h5A, 8'h6B, 8'h7C, 1'b1);

    fault_en = 1'b1;
    expect_run("fault", 0, 3, 8'h80, 8'h81, 8'h82, 8'h5A, 8'h6B, 8'h7C, 1'b0);
    fault_en = 1'b0;

    expect_run("wrap", 1, 3, 8'hFE, 8'hFF, 8'h00, 8'h5A, 8'h6B, 8'h7C, 1'b1);

    expect_run("one", 2, 1, 8'h80, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 1'b1);

    // Abort in the second WRITE cycle, then a clean run from IDLE.
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    check("abort_w0_addr", b_addr[0], 8'h80);
    step();
    check("abort_w1_addr", b_addr[0], 8'h81);
    check("abort_w1_data", b_dout[0], 8'h6B);
    rst_n = 1'b0;
    step();
    check_idle_bus("abort", 0);
    rst_n = 1'b1;
    step();
    check("abort_idle_we", 8'(b_we[0]), 8'h00);
    expect_run("after_abort", 0, 3, 8'h80, 8'h81, 8'h82, 8'h5A, 8'h6B, 8'h7C, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
